req_ack_arbiter: RTL

Round-robin arbiter that shares one req/ack-handshaked resource among `N_REQ` requesters. Each requester uses a four-phase req/ack handshake toward the arbiter. The arbiter forwards the selected request to the resource and tags it with the owner's index. A watchdog releases the resource if it never acknowledges, and optional embedded SVA checks both handshakes.

---
 rtl/req_ack_arb_pkg.sv | 19 +
 rtl/req_ack_arbiter_rr_pick.sv | 28 ++
 rtl/req_ack_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/req_ack_arb_pkg.sv
// Shared types and helpers for the round-robin req/ack arbiter.
package req_ack_arb_pkg;

  localparam int MAX_N_REQ = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } arb_state_e;

  // Modulo-n increment of a requester index (n up to MAX_N_REQ).
  function automatic logic [3:0] rr_next(input logic [3:0] ptr, input logic [4:0] n);
    logic [4:0] inc;
    inc = {1'b0, ptr} + 5'd1;
    return (inc >= n) ? 4'd0 : inc[3:0];
  endfunction

endpackage

// File: rtl/req_ack_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  int j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!valid && req[j[IDW-1:0]]) begin
        valid = 1'b1;
        idx   = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one req/ack resource among N_REQ four-phase requesters.
// Optional embedded handshake assertions are enabled with `define REQ_ACK_ARB_ASSERT_EN.
module req_ack_arbiter
  import req_ack_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             res_req,
  output logic [IDW-1:0]   res_id,
  input  logic             res_ack,
  output logic             err
);

  // Counter keeps at least one bit so TIMEOUT=0 (watchdog off) still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_e       state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   owner, owner_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [N_REQ-1:0] ack_nxt;
  logic             res_req_nxt;
  logic [IDW-1:0]   res_id_nxt;
  logic             err_nxt;
  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   owner_inc;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_inc = IDW'(rr_next(4'(owner), 5'(N_REQ)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      ack     <= '0;
      res_req <= 1'b0;
      res_id  <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      cnt     <= cnt_nxt;
      ack     <= ack_nxt;
      res_req <= res_req_nxt;
      res_id  <= res_id_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    cnt_nxt     = cnt;
    ack_nxt     = ack;
    res_req_nxt = res_req;
    res_id_nxt  = res_id;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nxt   = pick_idx;
          res_id_nxt  = pick_idx;
          res_req_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        // An acknowledge on the expiry edge takes priority over the watchdog.
        if (res_ack) begin
          res_req_nxt    = 1'b0;
          ack_nxt        = '0;
          ack_nxt[owner] = 1'b1;
          state_nxt      = ACK;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          res_req_nxt = 1'b0;
          err_nxt     = 1'b1;
          ptr_nxt     = owner_inc;
          state_nxt   = IDLE;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ACK: begin
        if (!req[owner]) begin
          ack_nxt   = '0;
          ptr_nxt   = owner_inc;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef REQ_ACK_ARB_ASSERT_EN
  a_ack_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(ack))
    $info("%0t: ack onehot0 holds", $time);
    else $error("%0t: ack not onehot0 (%b)", $time, ack);

  a_res_req_no_ack: assert property (@(posedge clk) disable iff (rst) res_req |-> !(|ack))
    $info("%0t: res_req without ack holds", $time);
    else $error("%0t: res_req high while ack=%b", $time, ack);

  for (genvar i = 0; i < N_REQ; i++) begin : g_ack_release
    a_ack_release: assert property (@(posedge clk) disable iff (rst)
                                    (ack[i] && !req[i]) |=> !ack[i])
      $info("%0t: ack[%0d] released", $time, i);
      else $error("%0t: ack[%0d] held after req dropped", $time, i);
  end

  a_rr_winner: assert property (@(posedge clk) disable iff (rst)
                                $rose(res_req) |-> res_id == $past(pick_idx))
    $info("%0t: round-robin winner %0d", $time, res_id);
    else $error("%0t: res_id %0d is not the round-robin winner", $time, res_id);

  a_err_pulse: assert property (@(posedge clk) disable iff (rst) err |=> !err)
    $info("%0t: err single-cycle", $time);
    else $error("%0t: err held longer than one cycle", $time);
`else
  // Assertions compiled out; behaviour is unchanged.
`endif

endmodule
